// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and pixel-address field layout for the LBP histogram.
package lbp_pkg;

    localparam int IMG_W_DEF = 128;
    localparam int CNT_W_DEF = 14;
    localparam int NBINS     = 256;
    localparam int BIN_W     = 8;
    localparam int COORD_W   = 7;
    localparam int ADDR_W    = 2 * COORD_W;
    localparam int ROW_LSB   = COORD_W;
    localparam int COL_LSB   = 0;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // LBP codes only exist where all eight neighbours do, so the one-pixel frame is illegal.
    function automatic logic is_interior(input logic [COORD_W-1:0] row,
                                         input logic [COORD_W-1:0] col,
                                         input int img_w);
        return (row != '0) && (col != '0) &&
               (int'(row) <= img_w - 2) && (int'(col) <= img_w - 2);
    endfunction

endpackage

// File: rtl/lbp_hist_bank.sv
// 256-bin counter bank: single-cycle saturating increment port plus one read port.
// Valid flags reset in one cycle; count storage is never reset.
module lbp_hist_bank
    import lbp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc_en_i,
    input  logic [BIN_W-1:0] inc_idx_i,
    output logic             inc_sat_o,
    input  logic [BIN_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_data_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_mem [NBINS];
    logic [NBINS-1:0] flag_vec;
    logic [CNT_W-1:0] inc_cur;
    logic [CNT_W-1:0] inc_new;
    logic [CNT_W-1:0] rd_raw;

    for (genvar gi = 0; gi < NBINS; gi++) begin : g_flag
        logic flag_bit_q;
        always_ff @(posedge clk) begin
            if (srst) begin
                flag_bit_q <= 1'b0;
            end else if (inc_en_i && (inc_idx_i == BIN_W'(gi))) begin
                flag_bit_q <= 1'b1;
            end
        end
        assign flag_vec[gi] = flag_bit_q;
    end

    assign inc_cur   = flag_vec[inc_idx_i] ? count_mem[inc_idx_i] : '0;
    assign inc_sat_o = inc_en_i && (inc_cur == CNT_MAX);
    assign inc_new   = (inc_cur == CNT_MAX) ? CNT_MAX : inc_cur + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (inc_en_i) begin
            count_mem[inc_idx_i] <= inc_new;
        end
    end

    // Forward a same-cycle increment so the first dumped bin sees a write made alongside finish.
    assign rd_raw    = flag_vec[rd_idx_i] ? count_mem[rd_idx_i] : '0;
    assign rd_data_o = (inc_en_i && (inc_idx_i == rd_idx_i)) ? inc_new : rd_raw;

endmodule

// File: rtl/lbp_hist.sv
// LBP histogram: accumulates codes into 256 bins, then streams them out with valid/ready.
// Holds the control FSM, the border-address filter and the registered output stage.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [BIN_W-1:0]  lbp_data,
    input  logic              lbp_finish,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [BIN_W-1:0]  hist_addr,
    output logic [CNT_W-1:0]  hist_data,
    output logic              done,
    output logic              hist_err
);

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [BIN_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]   data_q, data_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [COORD_W-1:0] pix_row;
    logic [COORD_W-1:0] pix_col;
    logic               interior;
    logic               inc_en;
    logic               inc_sat;
    logic [BIN_W-1:0]   rd_idx;
    logic [CNT_W-1:0]   rd_data;

    assign pix_row  = lbp_addr[ROW_LSB +: COORD_W];
    assign pix_col  = lbp_addr[COL_LSB +: COORD_W];
    assign interior = is_interior(pix_row, pix_col, IMG_W);
    assign inc_en   = lbp_valid && interior && (state_q == ST_ACCUM);

    // During the dump the read port looks one bin ahead so an accept reloads without a bubble.
    assign rd_idx = (state_q == ST_DUMP) ? addr_q + BIN_W'(1) : '0;

    lbp_hist_bank #(
        .CNT_W (CNT_W)
    ) u_bank (
        .clk       (clk),
        .srst      (reset),
        .inc_en_i  (inc_en),
        .inc_idx_i (lbp_data),
        .inc_sat_o (inc_sat),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        err_d   = err_q | inc_sat | (lbp_valid && !inc_en);
        case (state_q)
            ST_ACCUM: begin
                if (lbp_finish) begin
                    state_d = ST_DUMP;
                    valid_d = 1'b1;
                    addr_d  = '0;
                    data_d  = rd_data;
                end
            end
            ST_DUMP: begin
                if (hist_ready) begin
                    if (addr_q == BIN_W'(NBINS - 1)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + BIN_W'(1);
                        data_d = rd_data;
                    end
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ACCUM;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign hist_valid = valid_q;
    assign hist_addr  = addr_q;
    assign hist_data  = data_q;
    assign done       = done_q;
    assign hist_err   = err_q;

endmodule
